// File: rtl/load_scoreboard.sv
// Load scoreboard: single-outstanding load issue, per-register busy tracking,
// decode stall generation and write-back arbitration. Optional macro: LOAD_TIMEOUT_EN.
module load_scoreboard #(
   parameter int unsigned DATA_WIDTH     = 16,
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [2:0]            reg_read_adr1_d,
   input  logic [2:0]            reg_read_adr2_d,
   input  logic [2:0]            reg_write_adr_d,
   input  logic                  reg_write_d,
   input  logic                  mem_to_reg_d,
   input  logic                  load_issue_e,
   input  logic [2:0]            load_adr_e,
   output logic                  mem_req,
   input  logic                  mem_ack,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   input  logic                  reg_write_w,
   output logic                  wb_valid,
   output logic [2:0]            wb_adr,
   output logic [DATA_WIDTH-1:0] wb_data,
   output logic                  stall_sb,
   output logic [7:0]            busy_mask,
   output logic                  timeout_err
);

   localparam int unsigned NREG = 8;
   localparam int unsigned AW   = 3;

   typedef enum logic [1:0] {IDLE, WAIT_ACK, WB_PEND} state_t;

   state_t                r_state, w_state_nxt;
   logic [AW-1:0]         r_dest, w_dest_nxt;
   logic [DATA_WIDTH-1:0] r_data, w_data_nxt;
   logic [NREG-1:0]       r_busy, w_busy_nxt;
   logic                  r_mem_req;
   logic                  w_wb_valid;

`ifdef LOAD_TIMEOUT_EN
   localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 255) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
   logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
   logic             r_err;
   logic             w_timeout;
`endif

   // Next-state, busy bookkeeping and write-port arbitration
   always_comb begin
      w_state_nxt = r_state;
      w_dest_nxt  = r_dest;
      w_data_nxt  = r_data;
      w_busy_nxt  = r_busy;
      w_wb_valid  = 1'b0;
`ifdef LOAD_TIMEOUT_EN
      w_cnt_nxt   = r_cnt;
      w_timeout   = 1'b0;
`endif
      case (r_state)
         IDLE: begin
            if (load_issue_e) begin
               w_dest_nxt             = load_adr_e;
               w_busy_nxt[load_adr_e] = 1'b1;
               w_state_nxt            = WAIT_ACK;
`ifdef LOAD_TIMEOUT_EN
               w_cnt_nxt              = '0;
`endif
            end
         end
         WAIT_ACK: begin
            if (mem_ack) begin
               w_data_nxt  = mem_rdata;
               w_state_nxt = WB_PEND;
            end
`ifdef LOAD_TIMEOUT_EN
            else if (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
               w_timeout          = 1'b1;
               w_busy_nxt[r_dest] = 1'b0;
               w_state_nxt        = IDLE;
            end else begin
               w_cnt_nxt = r_cnt + CNT_W'(1);
            end
`endif
         end
         WB_PEND: begin
            // W-stage writes own the port; the load result waits.
            if (!reg_write_w) begin
               w_wb_valid         = 1'b1;
               w_busy_nxt[r_dest] = 1'b0;
               w_state_nxt        = IDLE;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state   <= IDLE;
         r_dest    <= '0;
         r_data    <= '0;
         r_busy    <= '0;
         r_mem_req <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_dest    <= w_dest_nxt;
         r_data    <= w_data_nxt;
         r_busy    <= w_busy_nxt;
         r_mem_req <= (w_state_nxt == WAIT_ACK);
      end
   end

`ifdef LOAD_TIMEOUT_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cnt <= '0;
         r_err <= 1'b0;
      end else begin
         r_cnt <= w_cnt_nxt;
         r_err <= r_err | w_timeout;
      end
   end

   assign timeout_err = r_err;
`else
   // No timeout hardware; the parameter only keeps the interface uniform.
   assign timeout_err = 1'b0 & (TIMEOUT_CYCLES == 0);
`endif

   assign mem_req   = r_mem_req;
   assign wb_valid  = w_wb_valid;
   assign wb_adr    = r_dest;
   assign wb_data   = r_data;
   assign busy_mask = r_busy;

   assign stall_sb = r_busy[reg_read_adr1_d]
                   | r_busy[reg_read_adr2_d]
                   | (reg_write_d & r_busy[reg_write_adr_d])
                   | (mem_to_reg_d & (r_state != IDLE))
                   | (load_issue_e & ((load_adr_e == reg_read_adr1_d) |
                                      (load_adr_e == reg_read_adr2_d)));

endmodule

// File: tb/tb_load_scoreboard.sv
// Bench for load_scoreboard: directed and random stimulus against a pending-load
// reference model; write-backs are checked by a separate scoreboard monitor.
module tb_load_scoreboard;

   localparam int unsigned DW = 16;
   localparam int unsigned TO = 4;
`ifdef LOAD_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          reset;
   logic [2:0]    reg_read_adr1_d, reg_read_adr2_d, reg_write_adr_d;
   logic          reg_write_d, mem_to_reg_d, load_issue_e;
   logic [2:0]    load_adr_e;
   logic          mem_req, mem_ack;
   logic [DW-1:0] mem_rdata;
   logic          reg_write_w, wb_valid;
   logic [2:0]    wb_adr;
   logic [DW-1:0] wb_data;
   logic          stall_sb;
   logic [7:0]    busy_mask;
   logic          timeout_err;

   always #5 clk = ~clk;

   load_scoreboard #(.DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .reset(reset),
      .reg_read_adr1_d(reg_read_adr1_d), .reg_read_adr2_d(reg_read_adr2_d),
      .reg_write_adr_d(reg_write_adr_d), .reg_write_d(reg_write_d),
      .mem_to_reg_d(mem_to_reg_d), .load_issue_e(load_issue_e),
      .load_adr_e(load_adr_e), .mem_req(mem_req), .mem_ack(mem_ack),
      .mem_rdata(mem_rdata), .reg_write_w(reg_write_w), .wb_valid(wb_valid),
      .wb_adr(wb_adr), .wb_data(wb_data), .stall_sb(stall_sb),
      .busy_mask(busy_mask), .timeout_err(timeout_err)
   );

   typedef struct {
      bit            rst, issue, ack, rw, rwd, mtr;
      logic [2:0]    ladr, a1, a2, wa;
      logic [DW-1:0] rd;
   } in_t;

   typedef struct packed {
      logic [2:0]    adr;
      logic [DW-1:0] data;
   } wb_t;

   int  checks = 0;
   int  errors = 0;
   wb_t exp_q[$];

   // Reference model: at most one pending load, described by what it has achieved so far.
   bit            m_pend, m_have, m_err;
   logic [2:0]    m_dest;
   logic [DW-1:0] m_data;
   int            m_wait;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", name, act, exp, $time);
      end
   endtask

   function automatic void model_clear();
      m_pend = 0; m_have = 0; m_err = 0; m_dest = '0; m_data = '0; m_wait = 0;
   endfunction

   function automatic logic [7:0] model_busy();
      return m_pend ? (8'h01 << m_dest) : 8'h00;
   endfunction

   // Advance the model across one rising edge using the inputs held during the cycle.
   function automatic void model_edge();
      if (reset) begin
         model_clear();
      end else if (!m_pend) begin
         if (load_issue_e) begin
            m_pend = 1; m_have = 0; m_dest = load_adr_e; m_wait = 0;
         end
      end else if (!m_have) begin
         if (mem_ack) begin
            m_have = 1; m_data = mem_rdata;
         end else if (TO_EN) begin
            m_wait++;
            if (m_wait == int'(TO)) begin
               m_err = 1; m_pend = 0;
            end
         end
      end else if (!reg_write_w) begin
         m_pend = 0;
      end
   endfunction

   function automatic in_t idle_in();
      in_t t;
      t = '{default: 0};
      return t;
   endfunction

   function automatic in_t rand_in();
      in_t t;
      t.rst   = ($urandom_range(99) == 0);
      t.issue = ($urandom_range(99) < 30);
      t.ack   = ($urandom_range(99) < 45);
      t.rw    = ($urandom_range(99) < 40);
      t.rwd   = $urandom_range(1) == 1;
      t.mtr   = ($urandom_range(99) < 25);
      t.ladr  = 3'($urandom_range(7));
      t.a1    = 3'($urandom_range(7));
      t.a2    = 3'($urandom_range(7));
      t.wa    = 3'($urandom_range(7));
      t.rd    = DW'($urandom);
      return t;
   endfunction

   task automatic step(input in_t n);
      logic [7:0] eb;
      logic       es;
      @(posedge clk);
      model_edge();
      #1;
      reset = n.rst; load_issue_e = n.issue; load_adr_e = n.ladr; mem_ack = n.ack;
      mem_rdata = n.rd; reg_write_w = n.rw; reg_read_adr1_d = n.a1;
      reg_read_adr2_d = n.a2; reg_write_adr_d = n.wa; reg_write_d = n.rwd;
      mem_to_reg_d = n.mtr;
      if (n.rst) begin
         chk("wb_missing_before_reset", 32'(exp_q.size()), 32'd0);
         exp_q.delete();
         model_clear();
      end
      #1;
      if (m_pend && m_have && !reg_write_w) exp_q.push_back({m_dest, m_data});
      eb = model_busy();
      es = eb[reg_read_adr1_d] || eb[reg_read_adr2_d] || (reg_write_d && eb[reg_write_adr_d])
         || (mem_to_reg_d && m_pend)
         || (load_issue_e && (load_adr_e == reg_read_adr1_d || load_adr_e == reg_read_adr2_d));
      chk("mem_req", 32'(mem_req), 32'(m_pend && !m_have));
      chk("busy_mask", 32'(busy_mask), 32'(eb));
      chk("stall_sb", 32'(stall_sb), 32'(es));
      chk("timeout_err", 32'(timeout_err), 32'(m_err));
   endtask

   // Scoreboard monitor: every DUT write-back must match the oldest predicted one.
   initial begin
      wb_t e;
      forever begin
         @(negedge clk);
         if (wb_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL wb_unexpected actual=wb_valid=1 adr=%0d required=no write-back t=%0t",
                        wb_adr, $time);
            end else begin
               e = exp_q.pop_front();
               chk("wb_adr", 32'(wb_adr), 32'(e.adr));
               chk("wb_data", 32'(wb_data), 32'(e.data));
            end
         end
      end
   end

   initial begin
      in_t t;
      reset = 1'b1; load_issue_e = 0; load_adr_e = '0; mem_ack = 0; mem_rdata = '0;
      reg_write_w = 0; reg_read_adr1_d = '0; reg_read_adr2_d = '0; reg_write_adr_d = '0;
      reg_write_d = 0; mem_to_reg_d = 0;
      model_clear();

      t = idle_in(); t.rst = 1; step(t); step(t);

      // Minimum-latency load to r3 with ack in the first request cycle
      t = idle_in(); t.issue = 1; t.ladr = 3'd3; step(t);
      t = idle_in(); t.ack = 1; t.rd = 16'h00A5; step(t);
      t = idle_in(); step(t); step(t); step(t);

      // RAW on r5, including the same-cycle bypass
      t = idle_in(); t.a1 = 3'd5; t.issue = 1; t.ladr = 3'd5; step(t);
      t = idle_in(); t.a1 = 3'd5; step(t);
      t.ack = 1; t.rd = 16'h1234; step(t);
      t = idle_in(); t.a1 = 3'd5; step(t); step(t); step(t);

      // Write-back held off by three W-stage writes
      t = idle_in(); t.issue = 1; t.ladr = 3'd2; step(t);
      t = idle_in(); t.ack = 1; t.rd = 16'hBEEF; step(t);
      t = idle_in(); t.rw = 1; t.wa = 3'd2; t.rwd = 1; step(t); step(t); step(t);
      t.rw = 0; step(t); step(t);

      // Second load while pending stalls decode; a forced issue is ignored
      t = idle_in(); t.issue = 1; t.ladr = 3'd6; step(t);
      t = idle_in(); t.mtr = 1; step(t);
      t = idle_in(); t.issue = 1; t.ladr = 3'd1; step(t);
      t = idle_in(); t.ack = 1; t.rd = 16'h0F0F; step(t);
      t = idle_in(); step(t); step(t);

      // Reset while waiting, then a late ack
      t = idle_in(); t.issue = 1; t.ladr = 3'd4; step(t);
      t = idle_in(); step(t);
      t.rst = 1; step(t);
      t = idle_in(); t.ack = 1; t.rd = 16'hDEAD; step(t);
      t = idle_in(); step(t); step(t);

      // No ack for a long time: timeout or indefinite wait depending on build
      t = idle_in(); t.issue = 1; t.ladr = 3'd7; step(t);
      t = idle_in(); t.a2 = 3'd7;
      for (int i = 0; i < 10; i++) step(t);
      t.ack = 1; t.rd = 16'h5A5A; step(t);
      t = idle_in(); step(t); step(t); step(t);

      // Random traffic
      for (int i = 0; i < 3000; i++) step(rand_in());

      t = idle_in(); step(t); step(t); step(t); step(t);
      @(negedge clk);
      #1;
      chk("wb_missing_at_end", 32'(exp_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/load_scoreboard.md
# load_scoreboard

Scoreboard and write-port arbiter for loads to the variable-latency data memory in the 5-stage pipeline. It issues one outstanding load at a time over a req/ack handshake and tracks a busy bit per architectural register (8 registers, 3-bit addresses). It raises a decode stall for RAW/WAW conflicts on a pending destination. It returns load data to the register file through the shared write port, yielding to the pipeline's W-stage writes. `stall_sb` is ORed into `stall_f`/`stall_d` next to the hazard unit.

## Interface
Parameters:
- DATA_WIDTH, 16, width of memory read data and write-back data
- TIMEOUT_CYCLES, 255, WAIT_ACK cycles before abort (used only with LOAD_TIMEOUT_EN)

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  pipeline clock, rising edge
- reset  in  1  asynchronous, active-high
- reg_read_adr1_d  in  3  decode source 1
- reg_read_adr2_d  in  3  decode source 2
- reg_write_adr_d  in  3  decode destination
- reg_write_d  in  1  decode instruction writes a register
- mem_to_reg_d  in  1  decode instruction is a load
- load_issue_e  in  1  valid load in execute, issue this cycle
- load_adr_e  in  3  destination of the issuing load
- mem_req  out  1  memory read request
- mem_ack  in  1  memory read complete, mem_rdata valid
- mem_rdata  in  DATA_WIDTH  read data
- reg_write_w  in  1  pipeline W stage owns write port this cycle
- wb_valid  out  1  scoreboard writes register file this cycle
- wb_adr  out  3  write-back address
- wb_data  out  DATA_WIDTH  write-back data
- stall_sb  out  1  stall F and D
- busy_mask  out  8  per-register pending-load bits
- timeout_err  out  1  sticky load-timeout flag

## Operation
- States: IDLE, WAIT_ACK, WB_PEND.
- IDLE, load_issue_e=1: latch load_adr_e into dest, set busy[load_adr_e], go to WAIT_ACK.
- IDLE, load_issue_e=0: no change.
- WAIT_ACK: mem_req=1. On mem_ack=1, latch mem_rdata and go to WB_PEND.
- WB_PEND: wb_valid = ~reg_write_w. W-stage writes always have priority.
  - When wb_valid=1: clear busy[dest], go to IDLE.
  - Otherwise hold data and state.
- wb_adr is dest; wb_data is the latched data. Both hold stable through WB_PEND.
- stall_sb is combinational and is 1 when any of these hold:
  - busy[reg_read_adr1_d] or busy[reg_read_adr2_d]
  - reg_write_d & busy[reg_write_adr_d] (WAW)
  - mem_to_reg_d & (state≠IDLE), which keeps loads single-outstanding
  - load_issue_e & (load_adr_e == reg_read_adr1_d or reg_read_adr2_d), the same-cycle RAW bypass
- load_issue_e while not IDLE is a protocol violation. It is ignored: no busy set, no state change.
- mem_ack while not in WAIT_ACK is ignored.
- All 8 registers are tracked, including r0.

## Timing
- Reset values: mem_req=0, wb_valid=0, wb_adr=0, wb_data=0, stall_sb per its inputs with busy_mask=0, busy_mask=0, timeout_err=0. State is IDLE.
- Reset mid-operation abandons the load with no write-back. A late mem_ack after reset is ignored.
- mem_req is registered. It rises in the cycle after load_issue_e and falls in the cycle after the mem_ack edge.
- mem_ack may arrive in the first mem_req cycle.
- Minimum latency, with no W conflict:
  - cycle 0: issue
  - cycle 1: req and ack
  - cycle 2: wb_valid=1
  - cycle 3: busy clear, dependent instruction leaves decode
- Each W-stage conflict cycle adds one cycle.
- busy changes only at clock edges. busy_mask is a direct register output.

## Configuration
- LOAD_TIMEOUT_EN defined: an 8-bit-or-wider counter counts WAIT_ACK cycles.
  - When the count reaches TIMEOUT_CYCLES without ack: timeout_err is set (sticky until reset), mem_req drops, busy[dest] clears, no write-back, go to IDLE.
  - The counter clears on entry to WAIT_ACK.
- LOAD_TIMEOUT_EN undefined: WAIT_ACK waits indefinitely, timeout_err is tied 0, and there is no counter.

## Test plan
- Reset, then load_issue_e=1 with load_adr_e=3; mem_ack in the first req cycle with mem_rdata=0x00A5.
  - Required: mem_req high for 1 cycle; wb_valid in cycle 2 with wb_adr=3, wb_data=0x00A5.
  - Required: busy_mask=0x08 during cycles 1–2, 0x00 in cycle 3.
- Load r5 pending, decode reads reg_read_adr1_d=5.
  - Required: stall_sb=1 until the cycle after write-back.
  - Same-cycle case: load_issue_e with load_adr_e=5 and decode src 5 gives stall_sb=1 in cycle 0.
- Ack received, reg_write_w=1 for 3 cycles.
  - Required: wb_valid=0 for 3 cycles, then 1 with data unchanged; busy clears after that.
- Load pending, mem_to_reg_d=1: stall_sb=1. A forced load_issue_e in WAIT_ACK leaves busy_mask unchanged.
- Assert reset in WAIT_ACK, then mem_ack=1 after reset.
  - Required: all outputs at reset values, no wb_valid.
- With LOAD_TIMEOUT_EN and TIMEOUT_CYCLES=4, no ack.
  - Required: timeout_err=1 after 4 WAIT_ACK cycles, busy_mask=0, state IDLE.
  - Without the macro: mem_req stays 1 and timeout_err stays 0.
